condlogic_mc: RTL
=================

# condlogic_mc

Conditional-execution and flag unit for the multicycle ARMv4 core. Sits directly downstream of the main control FSM. It consumes the FSM's raw write strobes (NextPC, RegW, MemW) and the decoder's PCS/FlagW. It returns architecturally gated PCWrite/RegWrite/MemWrite to the datapath, and holds the NZCV flag register, the per-instruction condition result and executed/skipped instruction counters.

## Interface
Parameters:
- CNT_W, 16, width of executed/skipped counters (wrap-around).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- Cond  input  4  instruction bits [31:28]; valid from the decode cycle until the next IRWrite.
- ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle.
- FlagW  input  2  [1]: write N,Z; [0]: write C,V (from ALU decoder).
- PCS  input  1  instruction writes PC conditionally (B, or data-processing with Rd=15).
- NextPC  input  1  unconditional PC+4 strobe from FSM (fetch).
- RegW  input  1  FSM register-write strobe.
- MemW  input  1  FSM memory-write strobe.
- IRWrite  input  1  FSM fetch strobe; the instruction register loads on this edge.
- PCWrite  output  1  gated PC enable.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated memory write enable.
- Flags  output  4  registered {N,Z,C,V}.
- CondEx  output  1  effective condition result for the current instruction.
- ExecCount  output  CNT_W  instructions whose condition passed.
- SkipCount  output  CNT_W  instructions whose condition failed.

## Operation
- Phase tracking: flop dec_q <= IRWrite each cycle. A cycle with dec_q=1 is the decode cycle.
- Condition evaluation, combinational cond_now from Cond and registered Flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 → 0 (NV, never executes).
- condex_q loads cond_now at the end of every decode cycle. It holds until the next decode cycle.
- Effective condition: CondEx = dec_q ? cond_now : condex_q.
- Gating, combinational:
  - PCWrite = NextPC | (PCS & CondEx).
  - RegWrite = RegW & CondEx.
  - MemWrite = MemW & CondEx.
- Flag update on rising edge:
  - If FlagW[1] & CondEx, load N,Z from ALUFlags[3:2].
  - If FlagW[0] & CondEx, load C,V from ALUFlags[1:0].
  - The two halves are independent.
- Counters: at the end of each decode cycle, ExecCount+1 if cond_now is 1, else SkipCount+1. Exactly one counter increments per decode cycle. Each wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (reset=0 at a rising edge): Flags=0000, condex_q=0, dec_q=0, ExecCount=0, SkipCount=0.
  - Outputs during and right after reset: CondEx=0; PCWrite=NextPC; RegWrite=0; MemWrite=0.
- Gating outputs are combinational, with zero latency from the FSM strobes. No registered delay is added to the FSM's Moore outputs.
- Flags written at edge k are visible to cond_now in cycle k+1. A decode cycle evaluates the flags left by the previous instruction's execute.
- FlagW asserted in the decode cycle uses cond_now, and Flags update at that edge. In that same cycle, condition evaluation uses the old Flags.
- IRWrite in two consecutive cycles: the second cycle is both fetch and decode. dec_q and the counter increment apply per edge.
- Reset mid-instruction: all state is cleared on that edge, and no counter increments on that edge even if dec_q=1.
- NextPC is never gated, so fetch always advances PC regardless of condex_q.

## Test plan
- Reset release, then FETCH with NextPC=1, RegW=1 → PCWrite=1, RegWrite=0, Flags=0000, counters 0.
- Set Z via FlagW=10, ALUFlags=0100 under AL. Next instruction Cond=0000 (EQ), RegW=1 in writeback → RegWrite=1, ExecCount +1.
- Same flags, Cond=0001 (NE), PCS=1, MemW=1 → PCWrite=0, MemWrite=0, SkipCount +1, Flags unchanged.
- Flags N=1,V=0, Cond=1011 (LT) → CondEx=1. Cond=1100 (GT) → CondEx=0. Cond=1111 → CondEx=0.
- FlagW=01 with ALUFlags=1111 under a passing condition → only C,V set (Flags=0011 from 0000). Under a failing condition → Flags unchanged.
- CNT_W=4, 16 passing instructions → ExecCount wraps to 0. Reset asserted during a decode cycle → both counters 0, no increment.

Source files
------------

// File: rtl/condlogic_mc.sv
// ---------------------------------------------------------------------------
// condlogic_mc
//
// Conditional-execution and flag unit for the multicycle ARMv4 core.
// Takes the raw write strobes from the main control FSM and gates them with
// the condition result of the current instruction. It also holds the NZCV
// flag register and counts executed and skipped instructions.
//
// Ports
//   clk        core clock, every state update happens on its rising edge
//   reset      synchronous active-low reset
//   Cond       instruction condition field (IR[31:28])
//   ALUFlags   {N,Z,C,V} produced by the ALU in the current cycle
//   FlagW      [1] write N,Z  [0] write C,V
//   PCS        instruction writes the PC conditionally
//   NextPC     unconditional PC+4 strobe (fetch)
//   RegW       FSM register-file write strobe
//   MemW       FSM memory write strobe
//   IRWrite    FSM fetch strobe (instruction register loads on this edge)
//   PCWrite    gated PC enable
//   RegWrite   gated register-file write enable
//   MemWrite   gated memory write enable
//   Flags      registered {N,Z,C,V}
//   CondEx     effective condition result for the current instruction
//   ExecCount  number of instructions whose condition passed (wraps)
//   SkipCount  number of instructions whose condition failed (wraps)
// ---------------------------------------------------------------------------
module condlogic_mc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CondEx,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    // ARM condition-code evaluation against a {N,Z,C,V} flag vector.
    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic res;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: res = z;                     // EQ
            4'b0001: res = ~z;                    // NE
            4'b0010: res = c;                     // CS
            4'b0011: res = ~c;                    // CC
            4'b0100: res = n;                     // MI
            4'b0101: res = ~n;                    // PL
            4'b0110: res = v;                     // VS
            4'b0111: res = ~v;                    // VC
            4'b1000: res = c & ~z;                // HI
            4'b1001: res = ~c | z;                // LS
            4'b1010: res = (n == v);              // GE
            4'b1011: res = (n != v);              // LT
            4'b1100: res = ~z & (n == v);         // GT
            4'b1101: res = z | (n != v);          // LE
            4'b1110: res = 1'b1;                  // AL
            4'b1111: res = 1'b0;                  // NV: never executes
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             dec_q,    dec_d;
    logic             condex_q, condex_d;
    logic [3:0]       flags_q,  flags_d;
    logic [CNT_W-1:0] exec_q,   exec_d;
    logic [CNT_W-1:0] skip_q,   skip_d;

    logic             cond_now_s;
    logic             condex_s;

    // Condition result from the currently held flags; in the decode cycle it
    // is used directly because condex_q still belongs to the previous instruction.
    always_comb begin
        cond_now_s = eval_cond(Cond, flags_q);
        if (dec_q) begin
            condex_s = cond_now_s;
        end else begin
            condex_s = condex_q;
        end
    end

    // Zero-latency gating of the FSM strobes; NextPC always passes so fetch advances.
    always_comb begin
        PCWrite  = NextPC | (PCS & condex_s);
        RegWrite = RegW & condex_s;
        MemWrite = MemW & condex_s;
        CondEx   = condex_s;
    end

    // Next-state logic for phase, latched condition, flags and counters.
    always_comb begin
        dec_d    = IRWrite;
        condex_d = condex_q;
        flags_d  = flags_q;
        exec_d   = exec_q;
        skip_d   = skip_q;

        // Exactly one counter moves per decode cycle.
        if (dec_q) begin
            condex_d = cond_now_s;
            if (cond_now_s) begin
                exec_d = exec_q + CNT_ONE;
            end else begin
                skip_d = skip_q + CNT_ONE;
            end
        end else begin
            condex_d = condex_q;
        end

        // N,Z and C,V halves are written independently.
        if (FlagW[1] & condex_s) begin
            flags_d[3:2] = ALUFlags[3:2];
        end else begin
            flags_d[3:2] = flags_q[3:2];
        end
        if (FlagW[0] & condex_s) begin
            flags_d[1:0] = ALUFlags[1:0];
        end else begin
            flags_d[1:0] = flags_q[1:0];
        end
    end

    // State register with synchronous active-low reset; reset wins over any increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dec_q    <= 1'b0;
            condex_q <= 1'b0;
            flags_q  <= 4'b0000;
            exec_q   <= {CNT_W{1'b0}};
            skip_q   <= {CNT_W{1'b0}};
        end else begin
            dec_q    <= dec_d;
            condex_q <= condex_d;
            flags_q  <= flags_d;
            exec_q   <= exec_d;
            skip_q   <= skip_d;
        end
    end

    assign Flags     = flags_q;
    assign ExecCount = exec_q;
    assign SkipCount = skip_q;

endmodule
